instr_prefetch_queue: RTL
=========================

# instr_prefetch_queue

Instruction prefetch buffer that sits directly upstream of the ESM scheduler. It accepts instruction words from fetch through a valid/ready handshake and holds them in a circular FIFO. Each cycle it presents one registered instruction, together with its decoded RegWrite/ALUSrc control bits, on the Instr_in/RegWrite/ALUSrc inputs of ESM. When the FIFO is empty it issues a NOP bubble, so ESM always sees a well-formed word every cycle.

## Interface
- Instruction_word_size, 32, instruction width; bits [6:0] are the RISC-V opcode.
- depth, 8, FIFO entries; power of two, ≥2.
- NOP, 32'h00000013, bubble word (addi x0,x0,0).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset; state clears immediately while rst=0.
- flush  input  1  synchronous discard of all queued and presented instructions.
- stall  input  1  downstream hold; freezes the output stage and blocks pops.
- in_valid  input  1  fetch presents in_instr.
- in_instr  input  Instruction_word_size  fetched instruction word.
- in_ready  output  1  queue can accept; equals (count != depth).
- Instr_out  output  Instruction_word_size  registered instruction to ESM.
- RegWrite  output  1  registered decode of Instr_out.
- ALUSrc  output  1  registered decode of Instr_out.
- out_valid  output  1  Instr_out is a real instruction, not a bubble.
- count  output  $clog2(depth)+1  current FIFO occupancy; output stage excluded.
- illegal_seen  output  1  sticky; an unknown opcode reached the output stage.

## Operation
- **FIFO storage**
  - Storage: depth words, with wr_ptr and rd_ptr of $clog2(depth) bits each.
  - Both pointers wrap modulo depth.
  - Occupancy is tracked by count, not by pointer comparison.
- **Push:** occurs when in_valid && in_ready && !flush.
  - Writes mem[wr_ptr] and increments wr_ptr.
- **Pop:** occurs when !stall && !flush && count != 0.
  - Loads the output stage from mem[rd_ptr] and increments rd_ptr.
- **Count update:** count += push − pop.
  - Push and pop in the same cycle leave count unchanged.
  - Push is never possible when count == depth, because in_ready=0.
- **Output stage update, when !stall && !flush:**
  - Pop: Instr_out = head word, decoded bits loaded, out_valid=1.
  - No pop (FIFO empty): Instr_out = NOP, RegWrite=0, ALUSrc=0, out_valid=0.
- **Output stage when stall=1:** output registers and rd_ptr hold. Pushes still proceed.
- **Flush:**
  - Next edge: pointers=0, count=0, output stage = bubble.
  - A push in the same cycle is discarded.
  - flush has priority over stall.
  - illegal_seen is not cleared by flush.
- **Decode** (opcode → RegWrite, ALUSrc):
  - 0110011 R-type → 1,0
  - 0010011 I-ALU → 1,1
  - 0000011 load → 1,1
  - 0100011 store → 0,1
  - 1100011 branch → 0,0
  - 0110111 LUI → 1,1
  - 0010111 AUIPC → 1,1
  - 1101111 JAL → 1,1
  - 1100111 JALR → 1,1
  - any other opcode → 0,0, and illegal_seen sets when that word is popped.
- **No bypass:** a word pushed into an empty FIFO is not presented in the same cycle.

## Timing
- **Reset values (rst=0):** wr_ptr=0, rd_ptr=0, count=0, Instr_out=NOP, RegWrite=0, ALUSrc=0, out_valid=0, illegal_seen=0.
  - in_ready=1 follows from count=0.
- **Latency:** a word accepted at edge N appears on Instr_out after edge N+1, provided stall=0 at N+1 and the FIFO was empty.
  - Otherwise it appears in FIFO order.
- **Throughput:** one instruction per cycle in steady state. in_ready drops in the cycle after count reaches depth.
- **in_ready** is combinational from count only. It does not depend on stall or pop in the same cycle, so a full queue refuses a push even when a pop occurs.
- **Wrap-around:** pointers roll from depth−1 to 0 with no gap in ordering.
- **Reset mid-operation:** all queued words are lost and the outputs return to reset values asynchronously.
  - First push after rst release is accepted at the first rising edge with rst=1.

## Test plan
- **Reset:** hold rst=0 with in_valid=1 → Instr_out=0x00000013, out_valid=0, count=0, in_ready=1. No push occurs.
- **Ordering and decode:** push add x1,x2,x3 (0x003100B3), then addi x4,x5,7 (0x00728213), then sw (0x0062A023), with stall=0.
  - Outputs appear in order one cycle after each push: (RegWrite,ALUSrc) = (1,0), then (1,1), then (0,1).
  - A bubble follows with out_valid=0.
- **Full and wrap:** hold stall=1 and push 8 words.
  - count=8 and in_ready=0; a 9th word is ignored.
  - Release stall: the 8 words come out in order on consecutive cycles.
  - Repeat 3 times to exercise pointer wrap.
- **Stall hold:** assert stall for 3 cycles while instruction A is on Instr_out → Instr_out stays A, count grows with pushes, no word is lost or duplicated.
- **Flush:** with count=5, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, Instr_out=NOP. The concurrent word is dropped.
- **Illegal opcode:** push 0x0000007F → output has RegWrite=0, ALUSrc=0, out_valid=1. illegal_seen=1 and remains set through a flush, clearing only on rst.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: circular instruction FIFO feeding ESM one registered, pre-decoded word per cycle,
// substituting a NOP bubble whenever the queue runs dry.
module instr_prefetch_queue #(
  parameter int Instruction_word_size = 32,
  parameter int depth = 8,
  parameter logic [Instruction_word_size-1:0] NOP = 32'h00000013
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             stall,
  input  logic                             in_valid,
  input  logic [Instruction_word_size-1:0] in_instr,
  output logic                             in_ready,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic                             RegWrite,
  output logic                             ALUSrc,
  output logic                             out_valid,
  output logic [$clog2(depth):0]           count,
  output logic                             illegal_seen
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL = (AW+1)'(depth);
  logic [Instruction_word_size-1:0] mem [depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [Instruction_word_size-1:0] head;
  logic push, pop, dec_rw, dec_as, dec_ok;
  assign in_ready = count != FULL;
  assign push = in_valid && in_ready && !flush;
  assign pop = !stall && !flush && count != '0;
  assign head = mem[rd_ptr];
  always_comb begin
    dec_rw = 1'b0;
    dec_as = 1'b0;
    dec_ok = 1'b1;
    case (head[6:0])
      7'b0110011: dec_rw = 1'b1;
      7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: {dec_rw, dec_as} = 2'b11;
      7'b0100011: dec_as = 1'b1;
      7'b1100011: dec_ok = 1'b1;
      default: dec_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_instr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      Instr_out <= NOP;
      RegWrite <= 1'b0;
      ALUSrc <= 1'b0;
      out_valid <= 1'b0;
      illegal_seen <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      Instr_out <= NOP;
      RegWrite <= 1'b0;
      ALUSrc <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (!stall) begin
        Instr_out <= pop ? head : NOP;
        RegWrite <= pop && dec_rw;
        ALUSrc <= pop && dec_as;
        out_valid <= pop;
      end
      if (pop && !dec_ok) illegal_seen <= 1'b1;
    end
  end
endmodule
